// File: rtl/enc_fun_sched.sv
// rtl/enc_fun_sched.sv - round-robin, break-before-make scheduler for the enc_FUN encoder
//
// Time-shares one enc_FUN instance between the LED bank (INTERF=0) and the
// LED matrix (INTERF=1).
//
// Parameters:
//   HOLD_CYCLES  cycles atv_PRIO stays high per grant window (1..255)
//   CNT_W        window counter width, 2**CNT_W > HOLD_CYCLES
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_A, in_B, in_C      raw input bits, latched on entry to SETUP
//   req_led, req_mat      level requests, held until granted
//   A, B, C               latched bits to the encoder
//   atv_PRIO              encoder enable
//   INTERF                encoder interface select (0 = LEDs, 1 = matrix)
//   gnt_led, gnt_mat      window active for the respective requester
//   busy                  high in SETUP, ACTIVE and GAP
//   done                  one-cycle pulse in the GAP after a full window
module enc_fun_sched #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_A,
    input  logic in_B,
    input  logic in_C,
    input  logic req_led,
    input  logic req_mat,
    output logic A,
    output logic B,
    output logic C,
    output logic atv_PRIO,
    output logic INTERF,
    output logic gnt_led,
    output logic gnt_mat,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACTIVE = 2'd2,
        GAP    = 2'd3
    } state_t;

    // Requester encoding shared by win/last/INTERF: 0 = LED, 1 = MAT.
    localparam logic SEL_MAT = 1'b1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               win_q, win_d;
    logic               a_q, a_d, b_q, b_d, c_q, c_d;
    logic               atv_q, atv_d;
    logic               interf_q, interf_d;
    logic               gnt_led_q, gnt_led_d;
    logic               gnt_mat_q, gnt_mat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               any_req;
    logic               pick;
    logic               win_req;

    // On a tie the requester that was not served last wins; otherwise the
    // sole requester wins (req_mat low implies LED).
    assign any_req = req_led | req_mat;
    assign pick    = (req_led && req_mat) ? ~last_q : req_mat;
    assign win_req = (win_q == SEL_MAT) ? req_mat : req_led;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        win_d   = win_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = SETUP;
                    win_d   = pick;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            SETUP: begin
                state_d = ACTIVE;
            end
            ACTIVE: begin
                // A window that has run its full length completes even if
                // the request falls on that same final edge.
                if (cnt_q == '0) begin
                    state_d = GAP;
                    done_d  = 1'b1;
                    last_d  = win_q;
                end else if (!win_req) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                // last_q already reflects the window that just finished.
                if (any_req) begin
                    state_d = SETUP;
                    win_d   = pick;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are the registered image of the next state, so nothing
        // reaches a port combinationally from an input.
        atv_d     = (state_d == ACTIVE);
        gnt_led_d = atv_d && (win_d != SEL_MAT);
        gnt_mat_d = atv_d && (win_d == SEL_MAT);
        busy_d    = (state_d != IDLE);

        // SETUP is only ever entered from IDLE or GAP, so this captures the
        // inputs and switches INTERF exactly once per window, with
        // atv_PRIO low.
        interf_d = interf_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        if (state_d == SETUP) begin
            interf_d = win_d;
            a_d      = in_A;
            b_d      = in_B;
            c_d      = in_C;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= SEL_MAT;
            win_q     <= 1'b0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            c_q       <= 1'b0;
            atv_q     <= 1'b0;
            interf_q  <= 1'b0;
            gnt_led_q <= 1'b0;
            gnt_mat_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            win_q     <= win_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            atv_q     <= atv_d;
            interf_q  <= interf_d;
            gnt_led_q <= gnt_led_d;
            gnt_mat_q <= gnt_mat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign C        = c_q;
    assign atv_PRIO = atv_q;
    assign INTERF   = interf_q;
    assign gnt_led  = gnt_led_q;
    assign gnt_mat  = gnt_mat_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_enc_fun_sched.sv
// tb/tb_enc_fun_sched.sv - scoreboard testbench for enc_fun_sched
module tb_enc_fun_sched;

    typedef struct packed {
        logic       interf;
        logic       a;
        logic       b;
        logic       c;
        logic       done;
        logic [7:0] len;
    } win_t;

    logic clk = 1'b0;
    logic rst_n;
    logic in_A, in_B, in_C;
    logic req_led, req_mat;
    logic A, B, C, atv_PRIO, INTERF, gnt_led, gnt_mat, busy, done;

    logic req_led1, req_mat1;
    logic A1, B1, C1, atv1, interf1, gnt_led1, gnt_mat1, busy1, done1;

    int errors = 0;
    int checks = 0;
    int viol   = 0;

    win_t exp_q[$];
    win_t obs_q[$];

    always #5 clk = ~clk;

    enc_fun_sched #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_A(in_A), .in_B(in_B), .in_C(in_C),
        .req_led(req_led), .req_mat(req_mat),
        .A(A), .B(B), .C(C),
        .atv_PRIO(atv_PRIO), .INTERF(INTERF),
        .gnt_led(gnt_led), .gnt_mat(gnt_mat),
        .busy(busy), .done(done)
    );

    enc_fun_sched #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_A(in_A), .in_B(in_B), .in_C(in_C),
        .req_led(req_led1), .req_mat(req_mat1),
        .A(A1), .B(B1), .C(C1),
        .atv_PRIO(atv1), .INTERF(interf1),
        .gnt_led(gnt_led1), .gnt_mat(gnt_mat1),
        .busy(busy1), .done(done1)
    );

    // Window monitor on the HOLD_CYCLES=4 instance: records each window and
    // counts break-before-make, exclusive-grant and latch-stability faults.
    logic       prev_atv = 1'b0;
    logic       prev_if  = 1'b0;
    logic       in_win   = 1'b0;
    win_t       cur;
    int         wlen = 0;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            in_win = 1'b0;
            wlen   = 0;
        end else begin
            if (atv_PRIO && !prev_atv) begin
                cur.interf = INTERF;
                cur.a      = A;
                cur.b      = B;
                cur.c      = C;
                wlen       = 1;
                in_win     = 1'b1;
            end else if (atv_PRIO) begin
                wlen = wlen + 1;
                if ({A, B, C} !== {cur.a, cur.b, cur.c}) viol = viol + 1;
            end else if (in_win) begin
                cur.len  = 8'(wlen);
                cur.done = done;
                obs_q.push_back(cur);
                in_win   = 1'b0;
            end
            if (gnt_led && gnt_mat) viol = viol + 1;
            if ((INTERF !== prev_if) && (atv_PRIO || prev_atv)) viol = viol + 1;
        end
        prev_atv = atv_PRIO;
        prev_if  = INTERF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        win_t e, o;
        do_reset();
        checks++;
        if ({A, B, C, atv_PRIO, INTERF, gnt_led, gnt_mat, busy, done} !== 9'b0) begin
            errors++;
            $display("FAIL reset_init: outputs=%b required=000000000",
                     {A, B, C, atv_PRIO, INTERF, gnt_led, gnt_mat, busy, done});
        end
        in_A = 1'b1; in_B = 1'b0; in_C = 1'b1;
        req_led = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (atv_PRIO !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_active: atv_PRIO=%b required=1", atv_PRIO);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({A, B, C, atv_PRIO, INTERF, gnt_led, gnt_mat, busy, done} !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid_active: outputs=%b required=000000000",
                     {A, B, C, atv_PRIO, INTERF, gnt_led, gnt_mat, busy, done});
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, atv_PRIO, INTERF, A, B, C} !== 6'b100101) begin
            errors++;
            $display("FAIL reset_fresh_setup: busy,atv,if,abc=%b required=100101",
                     {busy, atv_PRIO, INTERF, A, B, C});
        end
        exp_q.push_back('{interf: 1'b0, a: 1'b1, b: 1'b0, c: 1'b1, done: 1'b1, len: 8'd4});
        for (int i = 0; i < 5; i++) tick();
        req_led = 1'b0;
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL reset_window: no window observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL reset_window: got %h required %h", o, e);
                end
            end
        end
    endtask

    task automatic test_single_led();
        win_t e, o;
        do_reset();
        in_A = 1'b1; in_B = 1'b1; in_C = 1'b0;
        req_led = 1'b1;
        exp_q.push_back('{interf: 1'b0, a: 1'b1, b: 1'b1, c: 1'b0, done: 1'b1, len: 8'd4});
        tick();
        checks++;
        if ({busy, atv_PRIO, INTERF, A, B, C, gnt_led} !== 7'b1001100) begin
            errors++;
            $display("FAIL single_setup: busy,atv,if,abc,gnt=%b required=1001100",
                     {busy, atv_PRIO, INTERF, A, B, C, gnt_led});
        end
        for (int i = 2; i <= 5; i++) begin
            tick();
            checks++;
            if ({atv_PRIO, gnt_led, gnt_mat, done} !== 4'b1100) begin
                errors++;
                $display("FAIL single_active_%0d: atv,gl,gm,done=%b required=1100",
                         i, {atv_PRIO, gnt_led, gnt_mat, done});
            end
        end
        tick();
        checks++;
        if ({busy, atv_PRIO, gnt_led, done} !== 4'b1001) begin
            errors++;
            $display("FAIL single_gap: busy,atv,gl,done=%b required=1001",
                     {busy, atv_PRIO, gnt_led, done});
        end
        req_led = 1'b0;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: busy,done=%b required=00", {busy, done});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL single_window: no window observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL single_window: got %h required %h", o, e);
                end
            end
        end
    endtask

    task automatic test_tie_alternation();
        win_t e, o;
        int   n = 0;
        int   zeros = 0;
        logic prev = 1'b0;
        do_reset();
        in_A = 1'b0; in_B = 1'b1; in_C = 1'b1;
        exp_q.push_back('{interf: 1'b0, a: 1'b0, b: 1'b1, c: 1'b1, done: 1'b1, len: 8'd4});
        exp_q.push_back('{interf: 1'b1, a: 1'b0, b: 1'b1, c: 1'b1, done: 1'b1, len: 8'd4});
        exp_q.push_back('{interf: 1'b0, a: 1'b0, b: 1'b1, c: 1'b1, done: 1'b1, len: 8'd4});
        req_led = 1'b1;
        req_mat = 1'b1;
        for (int cyc = 0; cyc < 60 && n < 3; cyc++) begin
            tick();
            if (!atv_PRIO) zeros++;
            if (atv_PRIO && !prev && n > 0) begin
                checks++;
                if (zeros !== 2) begin
                    errors++;
                    $display("FAIL tie_gap_len: idle cycles=%0d required=2", zeros);
                end
            end
            if (atv_PRIO) zeros = 0;
            if (prev && !atv_PRIO) n++;
            prev = atv_PRIO;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL tie_timeout: windows=%0d required=3", n);
        end
        req_led = 1'b0;
        req_mat = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL tie_idle: busy=%b required=0", busy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL tie_window: no window observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL tie_window: got %h required %h", o, e);
                end
            end
        end
    endtask

    // Entered with last=LED from the previous test.
    task automatic test_abort();
        win_t e, o;
        logic prev = 1'b0;
        int   cyc;
        in_A = 1'b1; in_B = 1'b0; in_C = 1'b1;
        req_mat = 1'b1;
        exp_q.push_back('{interf: 1'b1, a: 1'b1, b: 1'b0, c: 1'b1, done: 1'b0, len: 8'd2});
        tick();
        tick();
        tick();
        checks++;
        if ({atv_PRIO, gnt_mat, gnt_led} !== 3'b110) begin
            errors++;
            $display("FAIL abort_active2: atv,gm,gl=%b required=110", {atv_PRIO, gnt_mat, gnt_led});
        end
        req_mat = 1'b0;
        tick();
        checks++;
        if ({busy, atv_PRIO, gnt_mat, done} !== 4'b1000) begin
            errors++;
            $display("FAIL abort_gap: busy,atv,gm,done=%b required=1000",
                     {busy, atv_PRIO, gnt_mat, done});
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b required=0", busy);
        end
        req_led = 1'b1;
        req_mat = 1'b1;
        exp_q.push_back('{interf: 1'b1, a: 1'b1, b: 1'b0, c: 1'b1, done: 1'b1, len: 8'd4});
        tick();
        checks++;
        if ({busy, INTERF} !== 2'b11) begin
            errors++;
            $display("FAIL abort_regrant: busy,INTERF=%b required=11", {busy, INTERF});
        end
        cyc = 0;
        while (!(prev && !atv_PRIO) && cyc < 20) begin
            prev = atv_PRIO;
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= 20) begin
            errors++;
            $display("FAIL abort_timeout: cycles=%0d required<20", cyc);
        end
        req_led = 1'b0;
        req_mat = 1'b0;
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL abort_window: no window observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL abort_window: got %h required %h", o, e);
                end
            end
        end
    endtask

    task automatic test_input_stability();
        win_t e, o;
        in_A = 1'b0; in_B = 1'b0; in_C = 1'b1;
        req_led = 1'b1;
        exp_q.push_back('{interf: 1'b0, a: 1'b0, b: 1'b0, c: 1'b1, done: 1'b1, len: 8'd4});
        tick();
        for (int i = 0; i < 5; i++) begin
            in_C = ~in_C;
            in_A = ~in_A;
            tick();
            checks++;
            if ({A, C} !== 2'b01) begin
                errors++;
                $display("FAIL stable_%0d: A,C=%b required=01", i, {A, C});
            end
        end
        req_led = 1'b0;
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL stable_window: no window observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL stable_window: got %h required %h", o, e);
                end
            end
        end
    endtask

    task automatic test_hold1();
        in_A = 1'b1; in_B = 1'b1; in_C = 1'b1;
        req_mat1 = 1'b1;
        tick();
        checks++;
        if ({busy1, atv1, interf1, A1, B1, C1} !== 6'b101111) begin
            errors++;
            $display("FAIL hold1_setup: busy,atv,if,abc=%b required=101111",
                     {busy1, atv1, interf1, A1, B1, C1});
        end
        tick();
        checks++;
        if ({atv1, gnt_mat1, gnt_led1, done1} !== 4'b1100) begin
            errors++;
            $display("FAIL hold1_active: atv,gm,gl,done=%b required=1100",
                     {atv1, gnt_mat1, gnt_led1, done1});
        end
        tick();
        checks++;
        if ({busy1, atv1, gnt_mat1, done1} !== 4'b1001) begin
            errors++;
            $display("FAIL hold1_gap: busy,atv,gm,done=%b required=1001",
                     {busy1, atv1, gnt_mat1, done1});
        end
        req_mat1 = 1'b0;
        tick();
        checks++;
        if ({busy1, done1} !== 2'b00) begin
            errors++;
            $display("FAIL hold1_idle: busy,done=%b required=00", {busy1, done1});
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL invariants: violations=%0d required=0", viol);
        end
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL extra_windows: unexpected=%0d required=0", obs_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_A = 1'b0; in_B = 1'b0; in_C = 1'b0;
        req_led = 1'b0; req_mat = 1'b0;
        req_led1 = 1'b0; req_mat1 = 1'b0;
        test_reset();
        test_single_led();
        test_tie_alternation();
        test_abort();
        test_input_stability();
        test_hold1();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enc_fun_sched.md
Name: enc_fun_sched

Overview:
- Scheduler that time-shares the enc_FUN functional encoder between its two consumer interfaces: the LED bank and the LED matrix.
- Latches the three input bits (A, B, C) for each transaction.
- Drives the encoder's enable (atv_PRIO) and interface select (INTERF) with break-before-make sequencing.
- Arbitrates round-robin between the LED requester and the matrix requester.
- Sits between the input switches/requesters and the enc_FUN instance.

Parameters:
- HOLD_CYCLES, 4, number of cycles atv_PRIO stays high per grant window; legal range 1..255.
- CNT_W, 8, width of the window counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_A  input  1  raw input bit A
- in_B  input  1  raw input bit B
- in_C  input  1  raw input bit C
- req_led  input  1  LED interface requests a display window (level, hold until granted)
- req_mat  input  1  matrix interface requests a display window (level, hold until granted)
- A  output  1  latched A to encoder
- B  output  1  latched B to encoder
- C  output  1  latched C to encoder
- atv_PRIO  output  1  encoder enable
- INTERF  output  1  encoder interface select: 0 = LEDs, 1 = matrix
- gnt_led  output  1  LED window active
- gnt_mat  output  1  matrix window active
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a window completes normally

Behaviour:
- Reset, sampled on a clk edge with rst_n=0, applies regardless of current state:
  - state=IDLE; A, B, C, atv_PRIO, INTERF, gnt_led, gnt_mat, busy, done all 0.
  - Round-robin pointer last=MAT, so LED wins the first tie.
  - Counter = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SETUP, ACTIVE, GAP.
- IDLE:
  - If req_led or req_mat: pick winner, go to SETUP.
  - Winner when both request: the one not equal to last. Otherwise the sole requester.
- SETUP (1 cycle):
  - Captures in_A/in_B/in_C into A/B/C.
  - INTERF = winner (LED→0, MAT→1).
  - atv_PRIO = 0; gnt_* = 0; busy = 1; counter loaded with HOLD_CYCLES-1.
- ACTIVE:
  - atv_PRIO = 1; gnt_<winner> = 1; INTERF and A/B/C held constant.
  - Counter decrements each cycle.
  - When counter=0 at a clk edge: go to GAP with done=1; last=winner.
- Abort:
  - If the winner's req deasserts during ACTIVE, go to GAP on the next edge.
  - done stays 0 and last is not updated.
- GAP (1 cycle):
  - atv_PRIO = 0; gnt_* = 0; INTERF holds its value; A/B/C hold.
  - done = 1 only in the GAP cycle following normal completion.
  - Next state: SETUP if any req (arbitrating with the updated last), else IDLE.
- Break-before-make: INTERF changes only in SETUP while atv_PRIO=0. atv_PRIO is never 1 in the cycle INTERF changes.
- gnt_led and gnt_mat are never both 1.
- Latency: req rises before edge n in IDLE → SETUP after edge n → atv_PRIO=1 after edge n+1. The window lasts exactly HOLD_CYCLES cycles.
- in_* changes during SETUP+1 .. GAP do not affect A/B/C.
- A request from the non-winner during ACTIVE is held pending, served after GAP.
- busy = 1 in SETUP, ACTIVE and GAP.

Test Plan:
1. Reset:
   - Stimulus: rst_n=0 for 2 cycles mid-ACTIVE, with req_led=1.
   - Response: next edge has all outputs 0 and state IDLE. After rst_n=1, a fresh SETUP starts.
2. Single LED request, HOLD_CYCLES=4:
   - Stimulus: in_A=1, in_B=1, in_C=0; req_led=1 at edge 0.
   - Response: SETUP at edge 1 with INTERF=0 and A,B,C=1,1,0. atv_PRIO=gnt_led=1 for edges 2-5. GAP at edge 6 with done=1. IDLE at edge 7 after req drop.
3. Tie then alternation:
   - Stimulus: req_led=req_mat=1 held.
   - Response: grant order LED, MAT, LED. INTERF toggles only in SETUP cycles; atv_PRIO=0 for 2 cycles (GAP+SETUP) between windows.
4. Abort:
   - Stimulus: req_mat drops in the 2nd ACTIVE cycle.
   - Response: GAP on the next edge with done=0. Next tie grants MAT again, since last was not updated.
5. Input stability:
   - Stimulus: toggle in_C every cycle during ACTIVE.
   - Response: C output constant at the value sampled in SETUP.
6. Parameter edge, HOLD_CYCLES=1:
   - Stimulus: single request.
   - Response: exactly one ACTIVE cycle with atv_PRIO=1, then done=1.
